// File: rtl/core_inst_pkg.sv
// rtl/core_inst_pkg.sv - shared sizes, inst bit map, state enum and idle word for core_inst_seq
// Purpose: common definitions imported by the sequencer, its interface and the ACC address generator.
// Ports: none (package).
package core_inst_pkg;

    localparam int COL      = 8;
    localparam int ROW      = 8;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_ONIJ = 16;
    localparam int NI_DIM   = 6;
    localparam int KI_DIM   = 3;
    localparam int O_NI_DIM = 4;
    localparam int GAP_CYC  = 10;
    localparam int W_BASE   = 1024;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    localparam int ACC_B      = 33;
    localparam int CEN_PMEM_B = 32;
    localparam int WEN_PMEM_B = 31;
    localparam int A_PMEM_LSB = 20;
    localparam int CEN_XMEM_B = 19;
    localparam int WEN_XMEM_B = 18;
    localparam int A_XMEM_LSB = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXECUTE_B  = 1;
    localparam int LOAD_B     = 0;

    // mode[1] selects dataflow, mode[0] selects precision
    localparam logic WS   = 1'b0;
    localparam logic OS   = 1'b1;
    localparam logic BIT4 = 1'b0;
    localparam logic BIT2 = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_GAP,
        S_X_FETCH,
        S_EXEC,
        S_DRAIN_WAIT,
        S_DRAIN,
        S_ACC_CLR,
        S_ACC_RD,
        S_ACC_GAP,
        S_ACC_OUT,
        S_DONE
    } state_t;

    // Both memories deselected and write-disabled, addresses 0, no strobes.
    function automatic logic [INST_W-1:0] inst_idle();
        logic [INST_W-1:0] w;
        w             = '0;
        w[CEN_PMEM_B] = 1'b1;
        w[WEN_PMEM_B] = 1'b1;
        w[CEN_XMEM_B] = 1'b1;
        w[WEN_XMEM_B] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// rtl/core_inst_seq_if.sv - controller-side bundle of the instruction sequencer
// Purpose: groups start/mode/ofifo_valid requests and the inst/sfp/status responses.
// Ports: start, mode[1:0], ofifo_valid (master drives); inst[33:0], sfp_clr, out_valid, out_idx[3:0], busy, done (slave drives).
interface core_inst_seq_if;
    import core_inst_pkg::*;

    logic              start;
    logic [1:0]        mode;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              sfp_clr;
    logic              out_valid;
    logic [3:0]        out_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, ofifo_valid,
        input  inst, sfp_clr, out_valid, out_idx, busy, done
    );

    modport slave (
        input  start, mode, ofifo_valid,
        output inst, sfp_clr, out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/acc_addr_gen.sv
// rtl/acc_addr_gen.sv - output-pixel / kernel-position counters and pmem address for the ACC pass
// Purpose: holds o (output pixel) and k (kernel position) and maps them to the psum address in pmem.
// Ports: clk, reset (async active-low), o_clr/o_inc, k_clr/k_inc counter controls; o[3:0] pixel index; a_pmem[10:0] read address.
module acc_addr_gen
    import core_inst_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              o_clr,
    input  logic              o_inc,
    input  logic              k_clr,
    input  logic              k_inc,
    output logic [3:0]        o,
    output logic [ADDR_W-1:0] a_pmem
);

    logic [3:0] k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o <= '0;
            k <= '0;
        end else begin
            if (o_clr)      o <= '0;
            else if (o_inc) o <= o + 4'd1;
            if (k_clr)      k <= '0;
            else if (k_inc) k <= k + 4'd1;
        end
    end

    // Psums of kernel position k sit in their own len_nij block; within it the
    // pixel is the input position that output o sees through kernel tap k.
    assign a_pmem = ADDR_W'(k) * ADDR_W'(LEN_NIJ)
                  + (ADDR_W'(o / 4'(O_NI_DIM)) + ADDR_W'(k / 4'(KI_DIM))) * ADDR_W'(NI_DIM)
                  + ADDR_W'(o % 4'(O_NI_DIM))
                  + ADDR_W'(k % 4'(KI_DIM));

endmodule

// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - instruction sequencer producing the 34-bit inst word for core
// Purpose: per kernel position runs weight fetch/load, gap, activation fetch, execute and OFIFO drain to pmem,
//          then accumulates every output pixel from pmem and flags it for the SFP.
// Ports: clk, reset (async active-low), bus (slave: start, mode, ofifo_valid in; inst, sfp_clr, out_valid, out_idx, busy, done out).
module core_inst_seq
    import core_inst_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.slave bus
);

    state_t            state, state_nx;
    logic [5:0]        t, t_nx;
    logic [3:0]        kij, kij_nx;
    logic              os_q, os_nx;
    logic [INST_W-1:0] inst_nx;
    logic              sfp_clr_nx, out_valid_nx, done_nx;
    logic [3:0]        out_idx_nx;
    logic              o_clr, o_inc, k_clr, k_inc;
    logic [3:0]        acc_o;
    logic [ADDR_W-1:0] acc_addr;

    acc_addr_gen u_acc_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .o_clr  (o_clr),
        .o_inc  (o_inc),
        .k_clr  (k_clr),
        .k_inc  (k_inc),
        .o      (acc_o),
        .a_pmem (acc_addr)
    );

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            t             <= '0;
            kij           <= '0;
            os_q          <= 1'b0;
            bus.inst      <= inst_idle();
            bus.sfp_clr   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nx;
            t             <= t_nx;
            kij           <= kij_nx;
            os_q          <= os_nx;
            bus.inst      <= inst_nx;
            bus.sfp_clr   <= sfp_clr_nx;
            bus.out_valid <= out_valid_nx;
            bus.out_idx   <= out_idx_nx;
            bus.done      <= done_nx;
        end
    end

    // Every output is decided from the current state and registered, so a
    // consumer strobe computed at t>=1 lands one cycle after the read at t-1.
    always_comb begin
        state_nx     = state;
        t_nx         = t + 6'd1;
        kij_nx       = kij;
        os_nx        = os_q;
        inst_nx      = inst_idle();
        sfp_clr_nx   = 1'b0;
        out_valid_nx = 1'b0;
        out_idx_nx   = '0;
        done_nx      = 1'b0;
        o_clr        = 1'b0;
        o_inc        = 1'b0;
        k_clr        = 1'b0;
        k_inc        = 1'b0;

        case (state)
            S_IDLE: begin
                t_nx   = '0;
                kij_nx = '0;
                o_clr  = 1'b1;
                if (bus.start) begin
                    state_nx = S_W_FETCH;
                    os_nx    = bus.mode[1];
                end
            end
            S_W_FETCH: begin
                if (t < 6'(COL)) begin
                    inst_nx[CEN_XMEM_B] = 1'b0;
                    inst_nx[A_XMEM_LSB +: ADDR_W] = ADDR_W'(W_BASE) + ADDR_W'(kij) * ADDR_W'(COL) + ADDR_W'(t);
                end
                if (t != 6'd0) begin
                    if (os_q == OS) inst_nx[IFIFO_WR_B] = 1'b1;
                    else            inst_nx[L0_WR_B]    = 1'b1;
                end
                if (t == 6'(COL)) begin
                    state_nx = S_W_LOAD;
                    t_nx     = '0;
                end
            end
            S_W_LOAD: begin
                inst_nx[LOAD_B] = (t < 6'(COL));
                if (os_q == OS) inst_nx[IFIFO_RD_B] = 1'b1;
                else            inst_nx[L0_RD_B]    = 1'b1;
                if (t == 6'(COL)) begin
                    state_nx = S_GAP;
                    t_nx     = '0;
                end
            end
            S_GAP: begin
                if (t == 6'(GAP_CYC - 1)) begin
                    state_nx = S_X_FETCH;
                    t_nx     = '0;
                end
            end
            S_X_FETCH: begin
                if (t < 6'(LEN_NIJ)) begin
                    inst_nx[CEN_XMEM_B] = 1'b0;
                    inst_nx[A_XMEM_LSB +: ADDR_W] = ADDR_W'(t);
                end
                inst_nx[L0_WR_B] = (t != 6'd0);
                if (t == 6'(LEN_NIJ)) begin
                    state_nx = S_EXEC;
                    t_nx     = '0;
                end
            end
            S_EXEC: begin
                // Tail of row+col cycles lets the last wavefront leave the array.
                inst_nx[EXECUTE_B] = (t < 6'(LEN_NIJ));
                inst_nx[L0_RD_B]   = (t < 6'(LEN_NIJ));
                if (t == 6'(LEN_NIJ + ROW + COL - 1)) begin
                    state_nx = S_DRAIN_WAIT;
                    t_nx     = '0;
                end
            end
            S_DRAIN_WAIT: begin
                t_nx = '0;
                if (bus.ofifo_valid) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                inst_nx[OFIFO_RD_B] = (t < 6'(LEN_NIJ));
                if (t != 6'd0) begin
                    inst_nx[CEN_PMEM_B] = 1'b0;
                    inst_nx[WEN_PMEM_B] = 1'b0;
                    inst_nx[A_PMEM_LSB +: ADDR_W] = ADDR_W'(kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(t) - 11'd1;
                end
                if (t == 6'(LEN_NIJ)) begin
                    t_nx     = '0;
                    kij_nx   = kij + 4'd1;
                    state_nx = (kij == 4'(LEN_KIJ - 1)) ? S_ACC_CLR : S_W_FETCH;
                end
            end
            S_ACC_CLR: begin
                sfp_clr_nx = 1'b1;
                k_clr      = 1'b1;
                t_nx       = '0;
                state_nx   = S_ACC_RD;
            end
            S_ACC_RD: begin
                if (t < 6'(LEN_KIJ)) begin
                    inst_nx[CEN_PMEM_B] = 1'b0;
                    inst_nx[A_PMEM_LSB +: ADDR_W] = acc_addr;
                    k_inc = 1'b1;
                end
                inst_nx[ACC_B] = (t != 6'd0);
                if (t == 6'(LEN_KIJ)) begin
                    state_nx = S_ACC_GAP;
                    t_nx     = '0;
                end
            end
            S_ACC_GAP: begin
                state_nx = S_ACC_OUT;
            end
            S_ACC_OUT: begin
                out_valid_nx = 1'b1;
                out_idx_nx   = acc_o;
                o_inc        = 1'b1;
                state_nx     = (acc_o == 4'(LEN_ONIJ - 1)) ? S_DONE : S_ACC_CLR;
            end
            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb/tb_core_inst_seq.sv - self-checking bench for core_inst_seq and acc_addr_gen
module tb_core_inst_seq;

    localparam int COL = 8, ROW = 8, LEN_NIJ = 36, LEN_KIJ = 9, LEN_ONIJ = 16;
    localparam int NI_DIM = 6, KI_DIM = 3, O_NI_DIM = 4, W_BASE = 1024;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam int BASE_CYCLES = LEN_KIJ * ((COL + 1) * 2 + 10 + (LEN_NIJ + 1) + (LEN_NIJ + ROW + COL) + 1 + (LEN_NIJ + 1))
                               + LEN_ONIJ * (1 + (LEN_KIJ + 1) + 1 + 1) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_inst_seq_if bus();
    core_inst_seq dut (.clk(clk), .reset(reset), .bus(bus));

    logic g_o_clr = 1'b0, g_o_inc = 1'b0, g_k_clr = 1'b0, g_k_inc = 1'b0;
    logic [3:0]  g_o;
    logic [10:0] g_addr;
    acc_addr_gen u_gen (.clk(clk), .reset(reset), .o_clr(g_o_clr), .o_inc(g_o_inc),
                        .k_clr(g_k_clr), .k_inc(g_k_inc), .o(g_o), .a_pmem(g_addr));

    int n_tests = 0, n_fail = 0;
    int xq[$], pwq[$], prq[$], oq[$], acc_log[$];
    int s_cnt[34];
    int cyc = 0, last_ov_cyc = 0, done_cyc = 0, done_cnt = 0, sfp_cnt = 0;
    logic [33:0] mw, prev_w;
    int base, c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_addr(input int o, input int k);
        return k * LEN_NIJ + (o / O_NI_DIM + k / KI_DIM) * NI_DIM + o % O_NI_DIM + k % KI_DIM;
    endfunction

    // Scoreboard monitor: every DUT memory access / output event pops its expectation.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_w = IDLE_W;
        end else begin
            mw = bus.inst;
            for (int b = 0; b < 34; b++) if (mw[b]) s_cnt[b]++;
            if (!mw[19]) begin
                check("xmem_rd_expected", xq.size() != 0, 1);
                check("xmem_rd_wen", mw[18], 1);
                if (xq.size() != 0) check("xmem_rd_addr", mw[17:7], xq.pop_front());
            end
            if (mw[2] || mw[5]) check("fifo_wr_trails_read", prev_w[19], 0);
            if (!mw[32] && !mw[31]) begin
                check("pmem_wr_expected", pwq.size() != 0, 1);
                if (pwq.size() != 0) check("pmem_wr_addr", mw[30:20], pwq.pop_front());
                check("pmem_wr_trails_ofifo_rd", prev_w[6], 1);
            end
            if (!mw[32] && mw[31]) begin
                check("pmem_rd_expected", prq.size() != 0, 1);
                if (prq.size() != 0) check("pmem_rd_addr", mw[30:20], prq.pop_front());
                acc_log.push_back(int'(mw[30:20]));
            end
            if (mw[33]) check("acc_trails_read", {prev_w[32], prev_w[31]}, 2'b01);
            if (bus.sfp_clr) sfp_cnt++;
            if (bus.out_valid) begin
                check("out_valid_expected", oq.size() != 0, 1);
                if (oq.size() != 0) check("out_idx", bus.out_idx, oq.pop_front());
                last_ov_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_w = mw;
        end
    end

    task automatic push_expected();
        for (int kij = 0; kij < LEN_KIJ; kij++) begin
            for (int t = 0; t < COL; t++) xq.push_back(W_BASE + kij * COL + t);
            for (int t = 0; t < LEN_NIJ; t++) xq.push_back(t);
            for (int t = 0; t < LEN_NIJ; t++) pwq.push_back(kij * LEN_NIJ + t);
        end
        for (int o = 0; o < LEN_ONIJ; o++) begin
            for (int k = 0; k < LEN_KIJ; k++) prq.push_back(ref_addr(o, k));
            oq.push_back(o);
        end
    endtask

    task automatic run_seq(input logic [1:0] md, input int hold_kij, input bit pulse, output int cycles);
        bit held, pulsed, fin;
        int rd0;
        int o5[9];
        o5 = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
        cycles = 0; held = 0; pulsed = 0; fin = 0;
        s_cnt = '{default: 0};
        done_cnt = 0; sfp_cnt = 0;
        acc_log.delete();
        push_expected();
        bus.mode = md;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!fin && cycles < 6000) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                check("first_wfetch_cen", bus.inst[19], 0);
                check("first_wfetch_addr", bus.inst[17:7], W_BASE);
            end
            if (cycles == 2) begin
                check("first_l0_wr", bus.inst[2], !md[1]);
                check("first_ififo_wr", bus.inst[5], md[1]);
            end
            if (bus.done) fin = 1;
            if (pulse && !pulsed && s_cnt[1] > 0) begin
                pulsed = 1;
                bus.start = 1'b1;
                bus.mode = ~md;
                @(posedge clk); #1;
                cycles++;
                bus.start = 1'b0;
            end
            if (hold_kij >= 0 && !held && s_cnt[1] == (hold_kij + 1) * LEN_NIJ) begin
                held = 1;
                bus.ofifo_valid = 1'b0;
                rd0 = s_cnt[6];
                repeat (40) begin
                    @(posedge clk); #1;
                    cycles++;
                    check("drain_wait_idle_word", bus.inst, IDLE_W);
                    check("drain_wait_busy", bus.busy, 1);
                end
                check("drain_wait_no_ofifo_rd", s_cnt[6], rd0);
                bus.ofifo_valid = 1'b1;
            end
        end
        check("done_within_budget", fin, 1);
        repeat (2) @(posedge clk);
        #1;
        check("n_l0_wr", s_cnt[2], (md[1] ? 0 : LEN_KIJ * COL) + LEN_KIJ * LEN_NIJ);
        check("n_ififo_wr", s_cnt[5], md[1] ? LEN_KIJ * COL : 0);
        check("n_l0_rd", s_cnt[3], (md[1] ? 0 : LEN_KIJ * (COL + 1)) + LEN_KIJ * LEN_NIJ);
        check("n_ififo_rd", s_cnt[4], md[1] ? LEN_KIJ * (COL + 1) : 0);
        check("n_load", s_cnt[0], LEN_KIJ * COL);
        check("n_execute", s_cnt[1], LEN_KIJ * LEN_NIJ);
        check("n_ofifo_rd", s_cnt[6], LEN_KIJ * LEN_NIJ);
        check("n_acc", s_cnt[33], LEN_ONIJ * LEN_KIJ);
        check("n_sfp_clr", sfp_cnt, LEN_ONIJ);
        check("n_done", done_cnt, 1);
        check("done_after_last_out_valid", done_cyc - last_ov_cyc, 1);
        check("xmem_queue_empty", xq.size(), 0);
        check("pmem_wr_queue_empty", pwq.size(), 0);
        check("pmem_rd_queue_empty", prq.size(), 0);
        check("out_queue_empty", oq.size(), 0);
        check("acc_log_size", acc_log.size(), LEN_ONIJ * LEN_KIJ);
        if (acc_log.size() == LEN_ONIJ * LEN_KIJ)
            for (int k = 0; k < 9; k++) check("acc_addr_o5", acc_log[5 * LEN_KIJ + k], o5[k]);
        check("idle_after_run", bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.ofifo_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", bus.inst, IDLE_W);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sfp_clr", bus.sfp_clr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx", bus.out_idx, 0);
        reset = 1'b1;

        // acc_addr_gen on its own
        g_o_clr = 1'b1; g_k_clr = 1'b1;
        @(posedge clk); #1;
        g_o_clr = 1'b0; g_k_clr = 1'b0;
        for (int o = 0; o < LEN_ONIJ; o++) begin
            check("gen_o", g_o, o);
            for (int k = 0; k < LEN_KIJ; k++) begin
                check("gen_addr", g_addr, ref_addr(o, k));
                g_k_inc = 1'b1;
                @(posedge clk); #1;
                g_k_inc = 1'b0;
            end
            g_k_clr = 1'b1; g_o_inc = 1'b1;
            @(posedge clk); #1;
            g_k_clr = 1'b0; g_o_inc = 1'b0;
        end

        run_seq(2'b00, -1, 0, base);
        check("baseline_cycles", base, BASE_CYCLES);
        run_seq(2'b10, 2, 0, c);
        run_seq(2'b01, -1, 1, c);
        check("start_during_exec_cycles", c, base);

        // reset in the middle of the kij=4 drain
        s_cnt = '{default: 0};
        push_expected();
        bus.mode = 2'b00;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 0;
        while (s_cnt[6] < 4 * LEN_NIJ + 10 && c < 6000) begin
            @(posedge clk); #1;
            c++;
        end
        check("reached_drain_kij4", s_cnt[6] >= 4 * LEN_NIJ + 10, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_inst", bus.inst, IDLE_W);
        check("async_rst_busy", bus.busy, 0);
        xq.delete(); pwq.delete(); prq.delete(); oq.delete();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_under_reset_ignored", bus.busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", bus.busy, 0);
        run_seq(2'b00, -1, 0, c);
        check("restart_cycles", c, base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
